// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_csum.sv
// Running XOR over the length and payload bytes; match compares against the incoming byte.
module prog_loader_csum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic              match
);

  logic [BYTE_W-1:0] acc;

  // clr with en starts a fresh sum seeded by the current byte
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= en ? data : '0;
    else if (en)
      acc <= acc ^ data;
  end

  assign match = (acc == data);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: byte stream -> big-endian 16-bit words -> instruction memory, holding the CPU in reset.
// Optional trailing XOR checksum enabled by defining PROG_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for the length byte
// HI    | waiting for the high byte of a word
// LO    | waiting for the low byte; accepting it writes the word
// CHECK | waiting for the checksum byte
// DONE  | image loaded, CPU released
// ERR   | checksum mismatch, CPU held in reset
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  words_left;
  logic [ADDR_W-1:0] addr;
  logic [BYTE_W-1:0] hi_byte;
  logic              xfer;
  logic              last_word;

  assign xfer      = in_valid && in_ready;
  assign last_word = (words_left == CNT_W'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic csum_clr;
  logic csum_en;
  logic csum_match;
  logic error_q;

  assign csum_clr = xfer && (state == IDLE);
  assign csum_en  = xfer && ((state == IDLE) || (state == HI) || (state == LO));

  prog_loader_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clr   (csum_clr),
    .en    (csum_en),
    .data  (in_data),
    .match (csum_match)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      words_left <= '0;
      addr       <= '0;
      hi_byte    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      error_q    <= 1'b0;
`endif
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            words_left <= (in_data == '0) ? FULL_CNT : CNT_W'(in_data);
            addr       <= '0;
            state      <= HI;
          end
        end
        HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            state   <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            im_we      <= 1'b1;
            im_addr    <= addr;
            im_wdata   <= {hi_byte, in_data};
            addr       <= addr + ADDR_W'(1);
            words_left <= words_left - CNT_W'(1);
            if (!last_word) begin
              state <= HI;
            end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              // release happens on the following edge, after this write lands
              state    <= DONE;
              in_ready <= 1'b0;
`endif
            end
          end
        end
        CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (xfer) begin
            in_ready <= 1'b0;
            if (csum_match) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state   <= ERR;
              error_q <= 1'b1;
            end
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          if (reload) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
          end else begin
            in_ready <= 1'b0;
            cpu_rst  <= 1'b0;
            done     <= 1'b1;
          end
        end
        ERR: begin
          if (reload) begin
            state    <= IDLE;
            in_ready <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            error_q  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the 16-bit single-cycle CPU's instruction memory. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes those words into instruction memory from address 0 and holds the CPU in reset until the image is fully written. Afterwards it releases the CPU and idles until a reload request.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word address width; 2^ADDR_W-entry memory, matching the CPU's 8-bit PC.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data holds a byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
- in_data  in  8  stream byte.
- reload  in  1  single-cycle request to re-enter load mode; honoured only in DONE or ERR.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  16  instruction word.
- cpu_rst  out  1  synchronous active-high reset to the CPU; 1 while loading.
- done  out  1  image loaded, CPU running.
- error  out  1  image rejected; only set when checksum is compiled in.

## Operation
- Stream format:
  - Byte 0 is the length N, in words; N=0 means 2^ADDR_W words.
  - Then 2N payload bytes, high byte first.
  - Then an optional checksum byte (see Configuration).
- FSM states: IDLE (wait length) -> HI -> LO -> (HI | CHECK | DONE); CHECK -> DONE | ERR; DONE/ERR -> IDLE on reload.
- IDLE: accept the length byte and load a remaining-word counter; the address counter is cleared to 0.
- HI: accept a byte into the high-byte register.
- LO: accept a byte. At the next edge, register im_wdata = {hi, byte} and im_addr = current address, pulse im_we, increment the address, and decrement the counter.
  - If the counter is not yet exhausted, go to HI.
  - If exhausted, go to CHECK when compiled in, else DONE.
- Address counter is ADDR_W bits. For N=0 the last write is to address 2^ADDR_W-1 and the counter wraps to 0 without further writes.
- DONE: cpu_rst=0, done=1, in_ready=0; extra stream bytes are not consumed.
- ERR: cpu_rst=1, error=1, in_ready=0.
- reload in DONE or ERR: next state IDLE; cpu_rst=1 and done=error=0 from the next cycle. reload in any other state is ignored.
- Memory contents are never cleared by the loader; a partial load leaves the words already written.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 (IDLE); im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, error=0. State is IDLE.
- in_ready = 1 in IDLE/HI/LO/CHECK, 0 in DONE/ERR. It has no other back-pressure, so one byte per cycle is sustained.
- Write latency: im_we is high in the cycle after the LO byte is accepted and lasts exactly one cycle.
- Release: without checksum, DONE is entered together with the final im_we cycle; cpu_rst falls at the following edge, two cycles after the last byte. The CPU's first fetch therefore sees a complete image.
- With checksum: done/cpu_rst update one edge after the checksum byte is accepted.
- rst mid-operation: abort at the next edge to IDLE; cpu_rst=1, done=0, error=0; a pending im_we is dropped.
- rst and reload simultaneous: rst wins.

## Configuration
- PROG_LOADER_CHECKSUM_EN defined:
  - A trailing checksum byte is expected, equal to the XOR of the length byte and all payload bytes.
  - Match -> DONE; mismatch -> ERR, with the CPU held in reset.
- Undefined: no CHECK state, error is tied to 0, and the stream ends after the last payload byte.

## Structure
- Shared package loader_pkg:
  - state enum (IDLE, HI, LO, CHECK, DONE, ERR);
  - constants BYTE_W=8, WORD_W=16, default ADDR_W=8.
- One sub-module, prog_loader_csum: a running XOR accumulator with clear/enable/match outputs. It is instantiated only under PROG_LOADER_CHECKSUM_EN.

## Test plan
- Reset -> cpu_rst=1, done=0, error=0, im_we=0; in_ready=1 one cycle after rst drops.
- Stream 02,12,34,AB,CD back-to-back -> im_we pulses with (0,0x1234) then (1,0xABCD); done=1; cpu_rst=0 two cycles after CD is accepted.
- Same stream with in_valid gaps of 0-3 cycles, plus 3 trailing bytes -> identical writes; trailing bytes are not accepted (in_ready=0 in DONE).
- PROG_LOADER_CHECKSUM_EN:
  - 01,00,0F,0E -> write (0,0x000F), done=1.
  - 01,00,0F,00 -> error=1, cpu_rst stays 1.
  - reload -> IDLE, error=0.
- N=00 with 512 payload bytes -> 256 writes, last at im_addr=0xFF, then DONE.
- rst pulsed after bytes 02,12,34 -> IDLE; a following stream 01,AA,55 writes (0,0xAA55). reload in DONE reasserts cpu_rst next cycle.
